// File: rtl/reaction_session_ctrl_if.sv
// Signal bundle between the session controller and its surroundings:
// start/button/random inputs in, LED, progress and score outputs back.
interface reaction_session_ctrl_if;
   logic       start;
   logic       btn;
   logic [7:0] rand_val;
   logic       led;
   logic       busy;
   logic [2:0] round_idx;
   logic [9:0] result;
   logic       result_valid;
   logic       false_start;
   logic [9:0] best;
   logic [9:0] avg;
   logic       session_done;

   modport master (
      output start, btn, rand_val,
      input  led, busy, round_idx, result, result_valid, false_start,
             best, avg, session_done
   );

   modport slave (
      input  start, btn, rand_val,
      output led, busy, round_idx, result, result_valid, false_start,
             best, avg, session_done
   );
endinterface

// File: rtl/reaction_session_ctrl.sv
// Multi-round reaction-time session sequencer. Runs on a free-running tick
// divider; each round waits a random number of ticks, lights the LED and
// times the button press. Tracks best time and the session average.
module reaction_session_ctrl #(
   parameter int CLK_DIV   = 500000,
   parameter int ROUNDS    = 5,
   parameter int MIN_WAIT  = 200,
   parameter int WAIT_SPAN = 201,
   parameter int MAX_REACT = 999
) (
   input logic                    clk,
   input logic                    rst,
   reaction_session_ctrl_if.slave bus
);

   localparam int DIV_W  = $clog2(CLK_DIV);
   localparam int WAIT_W = $clog2(MIN_WAIT + WAIT_SPAN);

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [9:0]       MAX_R    = 10'(MAX_REACT);
   localparam logic [2:0]       LAST_RND = 3'(ROUNDS - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT,
      S_LIGHT,
      S_RECORD,
      S_DONE
   } state_t;

   state_t             state;
   logic [DIV_W-1:0]   div_cnt;
   logic               tick;
   logic               start_prev;
   logic               btn_prev;
   logic               start_re;
   logic               btn_re;
   logic [WAIT_W-1:0]  wait_cnt;
   logic [9:0]         react_cnt;
   logic [9:0]         captured;
   logic [13:0]        sum;
   logic [13:0]        sum_next;

   logic               led;
   logic               busy;
   logic [2:0]         round_idx;
   logic [9:0]         result;
   logic               result_valid;
   logic               false_start;
   logic [9:0]         best;
   logic [9:0]         avg;
   logic               session_done;

   // Random wait length for a new round or after a false start.
   function automatic logic [WAIT_W-1:0] wait_load(input logic [7:0] r);
      return WAIT_W'(MIN_WAIT + (int'(r) % WAIT_SPAN));
   endfunction

   // Reaction counter increment that sticks at the timeout value.
   function automatic logic [9:0] sat_inc(input logic [9:0] v);
      return (v == MAX_R) ? v : v + 10'd1;
   endfunction

   function automatic logic [9:0] min10(input logic [9:0] a, input logic [9:0] b);
      return (b < a) ? b : a;
   endfunction

   // Floor of the session mean.
   function automatic logic [9:0] mean(input logic [13:0] total);
      return 10'(total / 14'(ROUNDS));
   endfunction

   assign tick     = (div_cnt == DIV_LAST);
   assign start_re = bus.start & ~start_prev;
   assign btn_re   = bus.btn & ~btn_prev;
   assign sum_next = sum + 14'(captured);

   // Free-running tick divider; the FSM never restarts it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)       div_cnt <= '0;
      else if (tick) div_cnt <= '0;
      else           div_cnt <= div_cnt + 1'b1;
   end

   // Previous levels of start and button for rising-edge detection.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         start_prev <= 1'b0;
         btn_prev   <= 1'b0;
      end else begin
         start_prev <= bus.start;
         btn_prev   <= bus.btn;
      end
   end

   // Session FSM; every output is registered and changes with the state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= S_IDLE;
         wait_cnt     <= '0;
         react_cnt    <= '0;
         captured     <= '0;
         sum          <= '0;
         led          <= 1'b0;
         busy         <= 1'b0;
         round_idx    <= '0;
         result       <= '0;
         result_valid <= 1'b0;
         false_start  <= 1'b0;
         best         <= MAX_R;
         avg          <= '0;
         session_done <= 1'b0;
      end else begin
         result_valid <= 1'b0;
         false_start  <= 1'b0;
         unique case (state)
            S_IDLE: begin
               if (start_re) begin
                  sum       <= '0;
                  best      <= MAX_R;
                  round_idx <= '0;
                  wait_cnt  <= wait_load(bus.rand_val);
                  busy      <= 1'b1;
                  state     <= S_WAIT;
               end
            end
            S_WAIT: begin
               // An early press restarts the wait and beats a same-cycle tick.
               if (btn_re) begin
                  false_start <= 1'b1;
                  wait_cnt    <= wait_load(bus.rand_val);
               end else if (tick) begin
                  if (wait_cnt == '0) begin
                     react_cnt <= '0;
                     led       <= 1'b1;
                     state     <= S_LIGHT;
                  end else begin
                     wait_cnt <= wait_cnt - 1'b1;
                  end
               end
            end
            S_LIGHT: begin
               // Press captures the count before any same-cycle increment.
               if (btn_re) begin
                  captured <= react_cnt;
                  led      <= 1'b0;
                  state    <= S_RECORD;
               end else if (tick) begin
                  if (react_cnt == MAX_R) begin
                     captured <= MAX_R;
                     led      <= 1'b0;
                     state    <= S_RECORD;
                  end else begin
                     react_cnt <= sat_inc(react_cnt);
                  end
               end
            end
            S_RECORD: begin
               result       <= captured;
               result_valid <= 1'b1;
               sum          <= sum_next;
               best         <= min10(best, captured);
               if (round_idx == LAST_RND) begin
                  avg          <= mean(sum_next);
                  busy         <= 1'b0;
                  session_done <= 1'b1;
                  state        <= S_DONE;
               end else begin
                  round_idx <= round_idx + 3'd1;
                  wait_cnt  <= wait_load(bus.rand_val);
                  state     <= S_WAIT;
               end
            end
            S_DONE: begin
               if (start_re) begin
                  session_done <= 1'b0;
                  state        <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign bus.led          = led;
   assign bus.busy         = busy;
   assign bus.round_idx    = round_idx;
   assign bus.result       = result;
   assign bus.result_valid = result_valid;
   assign bus.false_start  = false_start;
   assign bus.best         = best;
   assign bus.avg          = avg;
   assign bus.session_done = session_done;

endmodule

// File: tb/tb_reaction_session_ctrl.sv
// Bench for reaction_session_ctrl: directed sessions plus randomized rounds,
// checked against a tick-level model of the session rules.
module tb_reaction_session_ctrl;
   localparam int CLK_DIV   = 4;
   localparam int ROUNDS    = 3;
   localparam int MIN_WAIT  = 2;
   localparam int WAIT_SPAN = 3;
   localparam int MAX_REACT = 20;
   localparam int BOUND     = 2000;

   logic clk = 1'b0;
   logic rst = 1'b0;

   reaction_session_ctrl_if bus();

   reaction_session_ctrl #(
      .CLK_DIV  (CLK_DIV),
      .ROUNDS   (ROUNDS),
      .MIN_WAIT (MIN_WAIT),
      .WAIT_SPAN(WAIT_SPAN),
      .MAX_REACT(MAX_REACT)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Model of the tick base: clocks since reset, tick on every CLK_DIV-th.
   int cyc = 0;
   int tick_total = 0;
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         cyc        <= 0;
         tick_total <= 0;
      end else begin
         if (cyc % CLK_DIV == CLK_DIV - 1) tick_total <= tick_total + 1;
         cyc <= cyc + 1;
      end
   end

   // Session model state.
   int t0, t1, cur_load, sum_m, best_m, last_res;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic start_session(input int rv);
      bus.rand_val = 8'(rv);
      bus.start    = 1'b1;
      step();
      chk("start_busy", bus.busy, 1);
      chk("start_round", bus.round_idx, 0);
      chk("start_best", bus.best, MAX_REACT);
      chk("start_done", bus.session_done, 0);
      bus.start = 1'b0;
      t0       = tick_total;
      cur_load = MIN_WAIT + rv % WAIT_SPAN;
      sum_m    = 0;
      best_m   = MAX_REACT;
   endtask

   task automatic wait_led();
      int k;
      k = 0;
      while (bus.led !== 1'b1 && k < BOUND) begin
         step();
         k++;
      end
      chk("led_rise", bus.led, 1);
      chk("wait_ticks", tick_total - t0, cur_load + 1);
      t1 = tick_total;
   endtask

   // n >= MAX_REACT means no press (timeout); extra < 0 aligns the press to a tick.
   task automatic run_round(input int r, input int n, input int extra,
                            input bit fs, input int fs_rv);
      int k, exp_res, nrv;
      if (fs) begin
         step();
         step();
         chk("fs_pre_led", bus.led, 0);
         nrv = (fs_rv < 0) ? int'($urandom_range(0, 255)) : fs_rv;
         bus.rand_val = 8'(nrv);
         bus.btn      = 1'b1;
         step();
         chk("fs_pulse", bus.false_start, 1);
         chk("fs_no_result", bus.result_valid, 0);
         chk("fs_round", bus.round_idx, r);
         t0       = tick_total;
         cur_load = MIN_WAIT + nrv % WAIT_SPAN;
         bus.btn  = 1'b0;
         step();
         chk("fs_single", bus.false_start, 0);
      end
      wait_led();
      nrv = int'($urandom_range(0, 255));
      bus.rand_val = 8'(nrv);
      if (n < MAX_REACT) begin
         k = 0;
         while (tick_total - t1 < n && k < BOUND) begin
            step();
            k++;
         end
         if (extra < 0) begin
            k = 0;
            while (cyc % CLK_DIV != CLK_DIV - 1 && k < BOUND) begin
               step();
               k++;
            end
         end else begin
            repeat (extra) step();
         end
         exp_res = tick_total - t1;
         bus.btn = 1'b1;
         step();
         chk("press_led_off", bus.led, 0);
         bus.btn = 1'b0;
         step();
      end else begin
         exp_res = MAX_REACT;
         k = 0;
         while (bus.result_valid !== 1'b1 && k < BOUND) begin
            step();
            k++;
         end
         chk("timeout_ticks", tick_total - t1, MAX_REACT + 1);
      end
      chk("result_valid", bus.result_valid, 1);
      chk("result", bus.result, exp_res);
      chk("led_after", bus.led, 0);
      sum_m += exp_res;
      if (exp_res < best_m) best_m = exp_res;
      last_res = exp_res;
      if (r < ROUNDS - 1) begin
         chk("round_adv", bus.round_idx, r + 1);
         chk("busy_mid", bus.busy, 1);
         chk("not_done", bus.session_done, 0);
         t0       = tick_total;
         cur_load = MIN_WAIT + nrv % WAIT_SPAN;
      end else begin
         chk("done", bus.session_done, 1);
         chk("busy_done", bus.busy, 0);
         chk("best", bus.best, best_m);
         chk("avg", bus.avg, sum_m / ROUNDS);
      end
   endtask

   task automatic end_session();
      bus.start = 1'b1;
      step();
      chk("idle_done", bus.session_done, 0);
      chk("idle_busy", bus.busy, 0);
      chk("held_best", bus.best, best_m);
      chk("held_result", bus.result, last_res);
      chk("held_avg", bus.avg, sum_m / ROUNDS);
      bus.start = 1'b0;
      step();
   endtask

   task automatic random_session();
      int n, ex;
      start_session(int'($urandom_range(0, 255)));
      for (int r = 0; r < ROUNDS; r++) begin
         n  = int'($urandom_range(0, MAX_REACT + 2));
         ex = int'($urandom_range(0, 4)) - 1;
         run_round(r, n, ex, ($urandom_range(0, 3) == 0), -1);
      end
      end_session();
   endtask

   initial begin
      bus.start    = 1'b0;
      bus.btn      = 1'b0;
      bus.rand_val = 8'd0;
      #2 rst = 1'b1;
      step();
      step();
      chk("rst_led", bus.led, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_round", bus.round_idx, 0);
      chk("rst_result", bus.result, 0);
      chk("rst_rv", bus.result_valid, 0);
      chk("rst_fs", bus.false_start, 0);
      chk("rst_best", bus.best, MAX_REACT);
      chk("rst_avg", bus.avg, 0);
      chk("rst_done", bus.session_done, 0);
      rst = 1'b0;
      step();

      // Button in IDLE does nothing.
      bus.btn = 1'b1;
      step();
      chk("idle_btn_fs", bus.false_start, 0);
      chk("idle_btn_busy", bus.busy, 0);
      bus.btn = 1'b0;
      step();

      // Session 1: press at 5 ticks, false start then tick-aligned press, timeout.
      start_session(0);
      run_round(0, 5, 0, 1'b0, 0);
      run_round(1, 7, -1, 1'b1, 0);
      run_round(2, MAX_REACT + 1, 0, 1'b0, 0);
      end_session();

      // Session 2: results 4, 9, 2 -> best 2, avg 5.
      start_session(int'($urandom_range(0, 255)));
      run_round(0, 4, 0, 1'b0, 0);
      run_round(1, 9, 0, 1'b0, 0);
      run_round(2, 2, 0, 1'b0, 0);
      chk("dir_best", bus.best, 2);
      chk("dir_avg", bus.avg, 5);
      end_session();

      for (int s = 0; s < 4; s++) random_session();

      // Reset while the LED is lit.
      start_session(int'($urandom_range(0, 255)));
      wait_led();
      rst = 1'b1;
      #1;
      chk("arst_led", bus.led, 0);
      chk("arst_busy", bus.busy, 0);
      chk("arst_round", bus.round_idx, 0);
      chk("arst_result", bus.result, 0);
      chk("arst_best", bus.best, MAX_REACT);
      chk("arst_done", bus.session_done, 0);
      step();
      rst = 1'b0;
      step();
      random_session();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
